// File: rtl/mem_access_stage_if.sv
// Bundle of the execute-side offer, the data-memory req/gnt/rvalid port and the writeback record.
// The stage itself connects through the slave modport; its environment uses master.
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic        ex_alu_overflow;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_signed;
    logic [4:0]  ex_reg_dest;
    logic        ex_reg_write;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_reg_dest;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc_code;

    modport slave (
        input  ex_valid, ex_alu_result, ex_alu_overflow, ex_store_data, ex_mem_read,
               ex_mem_write, ex_mem_size, ex_mem_signed, ex_reg_dest, ex_reg_write,
        output ex_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_valid, wb_reg_dest, wb_reg_write, wb_data, wb_exc_code
    );

    modport master (
        output ex_valid, ex_alu_result, ex_alu_overflow, ex_store_data, ex_mem_read,
               ex_mem_write, ex_mem_size, ex_mem_signed, ex_reg_dest, ex_reg_write,
        input  ex_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_valid, wb_reg_dest, wb_reg_write, wb_data, wb_exc_code
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage after the execute ALU: one instruction per ex handshake, big-endian load/store over
// req/gnt/rvalid, with overflow, misalignment and bus-timeout exceptions and a one-cycle writeback pulse.
module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_access_stage_if.slave        bus,
    output logic [1:0]               o_dbg_state
);
    // Handshake: an instruction is taken on a rising edge where ex_valid && ex_ready; ex_ready is high
    // only in IDLE. mem_req and its address/data/enables hold steady until mem_gnt; rvalid closes a load.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic        r_is_load;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [4:0]  r_dest;
    logic        r_reg_write;
    logic [7:0]  r_wait_cnt;

    logic        r_wb_valid;
    logic [4:0]  r_wb_reg_dest;
    logic        r_wb_reg_write;
    logic [31:0] r_wb_data;
    logic [1:0]  r_wb_exc_code;

    logic        w_accept;
    logic        w_ex_is_mem;
    logic        w_ex_misaligned;
    logic        w_ex_mem_go;
    logic        w_timeout;
    logic        w_req_done;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_done;
    logic [1:0]  w_wb_exc;
    logic [31:0] w_wb_data;
    logic        w_wb_wr;
    logic [4:0]  w_wb_dest;

    assign w_accept    = bus.ex_valid && (r_state == S_IDLE);
    assign w_ex_is_mem = bus.ex_mem_read || bus.ex_mem_write;

    always_comb begin
        w_ex_misaligned = 1'b0;
        case (bus.ex_mem_size)
            2'b00:   w_ex_misaligned = 1'b0;
            2'b01:   w_ex_misaligned = bus.ex_alu_result[0];
            default: w_ex_misaligned = |bus.ex_alu_result[1:0];
        endcase
    end

    assign w_ex_mem_go = !bus.ex_alu_overflow && w_ex_is_mem && !w_ex_misaligned;
    assign w_timeout   = (r_state != S_IDLE) && (r_wait_cnt == LP_LAST);
    // A grant finishes a store, or a load whose data arrives in the same cycle.
    assign w_req_done  = bus.mem_gnt && (!r_is_load || bus.mem_rvalid);

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_rdata[31:24];
            2'd1:    w_byte = bus.mem_rdata[23:16];
            2'd2:    w_byte = bus.mem_rdata[15:8];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = r_addr[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        w_load_data = bus.mem_rdata;
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_wdata = r_sdata;
        w_be    = 4'b1111;
        case (r_size)
            2'b00: begin
                w_wdata = {4{r_sdata[7:0]}};
                w_be    = 4'b1000 >> r_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{r_sdata[15:0]}};
                w_be    = r_addr[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                w_wdata = r_sdata;
                w_be    = 4'b1111;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_ex_mem_go) w_next = S_REQ;
            S_REQ: begin
                if (w_req_done)       w_next = S_IDLE;
                else if (w_timeout)   w_next = S_IDLE;
                else if (bus.mem_gnt) w_next = S_WAIT;
            end
            S_WAIT: if (bus.mem_rvalid || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs and completion record
    always_comb begin
        w_done    = 1'b0;
        w_wb_exc  = 2'b00;
        w_wb_data = 32'h0;
        w_wb_wr   = 1'b0;
        w_wb_dest = r_dest;
        case (r_state)
            S_IDLE: begin
                w_wb_dest = bus.ex_reg_dest;
                if (w_accept) begin
                    if (bus.ex_alu_overflow) begin
                        w_done    = 1'b1;
                        w_wb_exc  = 2'b01;
                        w_wb_data = bus.ex_alu_result;
                    end else if (w_ex_is_mem && w_ex_misaligned) begin
                        w_done    = 1'b1;
                        w_wb_exc  = 2'b10;
                        w_wb_data = bus.ex_alu_result;
                    end else if (!w_ex_is_mem) begin
                        w_done    = 1'b1;
                        w_wb_data = bus.ex_alu_result;
                        w_wb_wr   = bus.ex_reg_write;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if ((r_state == S_REQ) ? w_req_done : bus.mem_rvalid) begin
                    w_done = 1'b1;
                    if (r_is_load) begin
                        w_wb_data = w_load_data;
                        w_wb_wr   = r_reg_write;
                    end
                end else if (w_timeout) begin
                    w_done    = 1'b1;
                    w_wb_exc  = 2'b11;
                    w_wb_data = r_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= 32'h0;
            r_sdata     <= 32'h0;
            r_is_load   <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_dest      <= 5'd0;
            r_reg_write <= 1'b0;
        end else if (w_accept) begin
            r_addr      <= bus.ex_alu_result;
            r_sdata     <= bus.ex_store_data;
            r_is_load   <= bus.ex_mem_read;
            r_size      <= bus.ex_mem_size;
            r_signed    <= bus.ex_mem_signed;
            r_dest      <= bus.ex_reg_dest;
            r_reg_write <= bus.ex_reg_write;
        end
    end

    // Counter is held at zero in IDLE so every trip through REQ starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_wait_cnt <= 8'd0;
        else if (r_state == S_IDLE) r_wait_cnt <= 8'd0;
        else                        r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_dest  <= 5'd0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'h0;
            r_wb_exc_code  <= 2'b00;
        end else begin
            r_wb_valid <= w_done;
            if (w_done) begin
                r_wb_reg_dest  <= w_wb_dest;
                r_wb_reg_write <= w_wb_wr;
                r_wb_data      <= w_wb_data;
                r_wb_exc_code  <= w_wb_exc;
            end
        end
    end

    assign bus.ex_ready     = (r_state == S_IDLE);
    assign bus.mem_req      = (r_state == S_REQ);
    assign bus.mem_we       = (r_state == S_REQ) && !r_is_load;
    assign bus.mem_addr     = (r_state == S_REQ) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_wdata    = (r_state == S_REQ && !r_is_load) ? w_wdata : 32'h0;
    assign bus.mem_be       = (r_state == S_REQ) ? w_be : 4'b0000;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg_dest  = r_wb_reg_dest;
    assign bus.wb_reg_write = r_wb_reg_write;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_exc_code  = r_wb_exc_code;
    assign o_dbg_state      = r_state;
endmodule
